board_supervisor: RTL

//   Parametrised avionics board supervisor: IDLE/STARTUP/RUNNING/SHUTDOWN sequencer with timed phases,

---
 rtl/board_supervisor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/board_supervisor.sv
// rtl/board_supervisor.sv - board power/run sequencer with arm toggle, radio-loss failsafe and fault capture
module board_supervisor #(
    parameter int TS_WIDTH       = 24,
    parameter int NUM_FAULT      = 4,
    parameter int STARTUP_TICKS  = 100,
    parameter int SHUTDOWN_TICKS = 50,
    parameter int FAILSAFE_TICKS = 500,
    parameter int AUTO_START     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 reset_req,
    input  logic                 arm_req,
    input  logic                 radio_ok,
    input  logic [NUM_FAULT-1:0] fault,
    input  logic [NUM_FAULT-1:0] fault_mask,
    output logic [1:0]           state,
    output logic                 subsys_rst,
    output logic                 motor_en,
    output logic                 failsafe,
    output logic [TS_WIDTH-1:0]  timestamp,
    output logic [NUM_FAULT-1:0] fault_latched
);

    localparam int PH_MAX = (STARTUP_TICKS > SHUTDOWN_TICKS) ? STARTUP_TICKS : SHUTDOWN_TICKS;
    localparam int PW     = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);
    localparam int WW     = $clog2(FAILSAFE_TICKS + 1);
    localparam logic [PW-1:0] ST_END = PW'(STARTUP_TICKS);
    localparam logic [PW-1:0] SD_END = PW'(SHUTDOWN_TICKS);
    localparam logic [WW-1:0] WD_END = WW'(FAILSAFE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STARTUP  = 2'd1,
        S_RUNNING  = 2'd2,
        S_SHUTDOWN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic                  failsafe_q, failsafe_d;
    logic                  motor_q, motor_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [NUM_FAULT-1:0]  latched_q, latched_d;
    logic                  rst_prev_q, rst_prev_d;
    logic                  arm_prev_q, arm_prev_d;

    logic                  rise_rst, rise_arm, flt, stay_run;
    logic [NUM_FAULT-1:0]  flt_vec;
    logic [PW-1:0]         phase_inc;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        latched_d  = latched_q;
        rst_prev_d = reset_req;
        arm_prev_d = arm_req;
        wd_d       = '0;
        failsafe_d = 1'b0;
        ts_d       = '0;
        motor_d    = 1'b0;

        rise_rst  = reset_req & ~rst_prev_q;
        rise_arm  = arm_req & ~arm_prev_q;
        flt_vec   = fault & fault_mask;
        flt       = |flt_vec;
        phase_inc = phase_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (AUTO_START != 0 || rise_rst) begin
                    state_d   = S_STARTUP;
                    phase_d   = '0;
                    latched_d = '0;
                end
            end
            S_STARTUP: begin
                latched_d = latched_q | flt_vec;
                if (rise_rst) begin
                    state_d = S_SHUTDOWN;
                    phase_d = '0;
                end else if (tick) begin
                    if (phase_inc == ST_END) begin
                        state_d = flt ? S_SHUTDOWN : S_RUNNING;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_inc;
                    end
                end
            end
            S_RUNNING: begin
                latched_d = latched_q | flt_vec;
                if (rise_rst || flt) begin
                    state_d = S_SHUTDOWN;
                    phase_d = '0;
                end
            end
            default: begin
                if (tick) begin
                    if (phase_inc == SD_END) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_inc;
                    end
                end
            end
        endcase

        // Run-only registers are zeroed on the exit edge, so motor_en drops with the state change
        stay_run = (state_q == S_RUNNING) && (state_d == S_RUNNING);
        if (stay_run) begin
            if (radio_ok)
                wd_d = '0;
            else if (tick && wd_q != WD_END)
                wd_d = wd_q + 1'b1;
            else
                wd_d = wd_q;
            failsafe_d = (wd_d == WD_END);
            ts_d       = ts_q + TS_WIDTH'(tick);
            if (failsafe_d && !failsafe_q)
                motor_d = 1'b0;
            else if (rise_arm)
                motor_d = ~motor_q & ~failsafe_q;
            else
                motor_d = motor_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            wd_q       <= '0;
            failsafe_q <= 1'b0;
            motor_q    <= 1'b0;
            ts_q       <= '0;
            latched_q  <= '0;
            rst_prev_q <= 1'b1;
            arm_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wd_q       <= wd_d;
            failsafe_q <= failsafe_d;
            motor_q    <= motor_d;
            ts_q       <= ts_d;
            latched_q  <= latched_d;
            rst_prev_q <= rst_prev_d;
            arm_prev_q <= arm_prev_d;
        end
    end

    assign state         = state_q;
    assign subsys_rst    = (state_q == S_IDLE);
    assign motor_en      = motor_q;
    assign failsafe      = failsafe_q;
    assign timestamp     = ts_q;
    assign fault_latched = latched_q;

endmodule
